// File: rtl/pc_sequencer.sv
// Instruction-fetch PC controller: owns the PC, picks sequential / branch / jump targets,
// raises the IF/ID flush after a redirect, and gates advance under stall, halt and debug run/step.
module pc_sequencer #(
    parameter int unsigned         BITS_SIZE = 32,
    parameter logic [BITS_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_step_mode,
    input  logic                 i_step,
    input  logic                 i_stall,
    input  logic                 i_branch_taken,
    input  logic [BITS_SIZE-1:0] i_branch_offset,
    input  logic [BITS_SIZE-1:0] i_branch_pc4,
    input  logic                 i_jump,
    input  logic [BITS_SIZE-1:0] i_jump_addr,
    input  logic                 i_halt,
    output logic [BITS_SIZE-1:0] o_pc,
    output logic [BITS_SIZE-1:0] o_pc4,
    output logic                 o_flush,
    output logic                 o_pc_valid,
    output logic                 o_halted
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [BITS_SIZE-1:0] FOUR       = BITS_SIZE'(4);
    localparam logic [BITS_SIZE-1:0] WORD_ALIGN = {{(BITS_SIZE-2){1'b1}}, 2'b00};

    state_t               state_q, state_d;
    logic [BITS_SIZE-1:0] pc_q, pc_d;
    logic                 flush_q, flush_d;

    logic                 advance;
    logic [BITS_SIZE-1:0] seq_pc;
    logic [BITS_SIZE-1:0] branch_target;
    logic [BITS_SIZE-1:0] jump_target;

    assign seq_pc        = pc_q + FOUR;
    // Shift discards the offset's top bits; the sum wraps modulo 2^BITS_SIZE.
    assign branch_target = (i_branch_offset << 2) + i_branch_pc4;
    assign jump_target   = i_jump_addr & WORD_ALIGN;

    assign advance = (state_q == RUN) || ((state_q == STEP) && i_step);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flush_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = i_step_mode ? STEP : RUN;
                end
            end
            RUN, STEP: begin
                if (advance) begin
                    if (i_halt) begin
                        state_d = HALTED;
                    end else if (i_stall) begin
                        // Redirect stays pending in ID; nothing consumed this cycle.
                        pc_d = pc_q;
                    end else if (i_jump) begin
                        pc_d    = jump_target;
                        flush_d = 1'b1;
                    end else if (i_branch_taken) begin
                        pc_d    = branch_target;
                        flush_d = 1'b1;
                    end else begin
                        pc_d = seq_pc;
                    end
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
        end
    end

    always_comb begin
        o_pc_valid = 1'b0;
        case (state_q)
            RUN:     o_pc_valid = 1'b1;
            STEP:    o_pc_valid = i_step;
            default: o_pc_valid = 1'b0;
        endcase
    end

    assign o_pc     = pc_q;
    assign o_pc4    = seq_pc;
    assign o_flush  = flush_q && (state_q != HALTED);
    assign o_halted = (state_q == HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer: hand-computed PC/flush/valid/halted expectations.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start, step_mode, step, stall, br_taken, jump, halt;
    logic [31:0] br_off, br_pc4, jump_addr;
    logic [31:0] pc, pc4;
    logic        flush, pc_valid, halted;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(.BITS_SIZE(32), .RESET_PC(32'h0)) dut (
        .i_clk          (clk),
        .i_reset        (rst_n),
        .i_start        (start),
        .i_step_mode    (step_mode),
        .i_step         (step),
        .i_stall        (stall),
        .i_branch_taken (br_taken),
        .i_branch_offset(br_off),
        .i_branch_pc4   (br_pc4),
        .i_jump         (jump),
        .i_jump_addr    (jump_addr),
        .i_halt         (halt),
        .o_pc           (pc),
        .o_pc4          (pc4),
        .o_flush        (flush),
        .o_pc_valid     (pc_valid),
        .o_halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] e_pc, input logic e_flush,
                             input logic e_valid, input logic e_halted);
        chk({tag, ".pc"},     pc,                e_pc);
        chk({tag, ".pc4"},    pc4,               e_pc + 32'd4);
        chk({tag, ".flush"},  {31'd0, flush},    {31'd0, e_flush});
        chk({tag, ".valid"},  {31'd0, pc_valid}, {31'd0, e_valid});
        chk({tag, ".halted"}, {31'd0, halted},   {31'd0, e_halted});
    endtask

    initial begin
        rst_n = 1'b0; start = 0; step_mode = 0; step = 0; stall = 0;
        br_taken = 0; jump = 0; halt = 0;
        br_off = '0; br_pc4 = '0; jump_addr = '0;
        #12;
        chk_state("reset", 32'h0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        chk_state("idle", 32'h0, 0, 0, 0);

        // Continuous run from reset PC
        start = 1; step_mode = 0;
        tick;
        start = 0; #1;
        chk_state("run0", 32'h0, 0, 1, 0);
        tick; chk_state("run4", 32'h4, 0, 1, 0);
        tick; chk_state("run8", 32'h8, 0, 1, 0);
        tick; chk_state("run12", 32'hC, 0, 1, 0);
        repeat (5) tick;
        chk_state("run20", 32'h20, 0, 1, 0);

        // Backward taken branch: 0x20 + (-2<<2) = 0x18
        br_taken = 1; br_off = 32'hFFFF_FFFE; br_pc4 = 32'h20;
        tick;
        br_taken = 0; #1;
        chk_state("br_tgt", 32'h18, 1, 1, 0);
        tick; chk_state("br_seq", 32'h1C, 0, 1, 0);

        // Stall beats a jump; jump consumed once stall drops, low bits forced to 0
        stall = 1; jump = 1; jump_addr = 32'h103;
        tick; chk_state("stall1", 32'h1C, 0, 1, 0);
        tick; chk_state("stall2", 32'h1C, 0, 1, 0);
        stall = 0;
        tick;
        jump = 0; #1;
        chk_state("jmp_tgt", 32'h100, 1, 1, 0);
        tick; chk_state("jmp_seq", 32'h104, 0, 1, 0);

        // Jump wins over branch, then back-to-back redirect to near-top of address space
        jump = 1; jump_addr = 32'h200; br_taken = 1; br_off = 32'h10; br_pc4 = 32'h104;
        tick;
        br_taken = 0; jump_addr = 32'hFFFF_FFF8; #1;
        chk_state("jmp_win", 32'h200, 1, 1, 0);
        tick;
        jump = 0; #1;
        chk_state("b2b", 32'hFFFF_FFF8, 1, 1, 0);
        tick; chk_state("wrap_fc", 32'hFFFF_FFFC, 0, 1, 0);
        tick; chk_state("wrap_0", 32'h0, 0, 1, 0);

        // Halt at 0x40
        jump = 1; jump_addr = 32'h40;
        tick;
        jump = 0; halt = 1; #1;
        chk_state("pre_halt", 32'h40, 1, 1, 0);
        tick;
        halt = 0; jump = 1; jump_addr = 32'h500; #1;
        chk_state("halted", 32'h40, 0, 0, 1);
        tick; chk_state("halted2", 32'h40, 0, 0, 1);

        // Asynchronous reset mid-HALTED
        #2 rst_n = 1'b0; jump = 0;
        #1;
        chk_state("arst", 32'h0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick; chk_state("idle2", 32'h0, 0, 0, 0);

        // Single-step mode
        start = 1; step_mode = 1;
        tick;
        start = 0; #1;
        chk_state("step_c1", 32'h0, 0, 0, 0);
        tick; chk_state("step_c2", 32'h0, 0, 0, 0);
        step = 1; #1;
        chk_state("step_c3", 32'h0, 0, 1, 0);
        tick;
        step = 0; #1;
        chk_state("step_c4", 32'h4, 0, 0, 0);
        tick; chk_state("step_c5", 32'h4, 0, 0, 0);
        tick; chk_state("step_c6", 32'h4, 0, 0, 0);
        step = 1; #1;
        chk_state("step_c7", 32'h4, 0, 1, 0);
        tick;
        step = 0; #1;
        chk_state("step_c8", 32'h8, 0, 0, 0);

        // Without i_step the redirect inputs are ignored; with it the jump is taken
        jump = 1; jump_addr = 32'h300; halt = 1;
        tick; chk_state("step_ign", 32'h8, 0, 0, 0);
        halt = 0; step = 1;
        tick;
        step = 0; jump = 0; #1;
        chk_state("step_jmp", 32'h300, 1, 0, 0);
        tick; chk_state("step_hold", 32'h300, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Instruction-fetch PC controller for the MIPS pipeline. Owns the program counter register and sequences the branch-target adder path: each cycle it selects sequential PC+4, a taken-branch target ((offset<<2) + PC+4), or a jump target. It also generates the IF/ID flush and gates PC advance under hazard stalls and debug run/step control. It sits between the ID-stage branch/jump resolution, the hazard unit, the debug unit and the instruction memory address port.

## Interface
- BITS_SIZE, 32, width of PC, offsets and targets
- RESET_PC, 0, PC value loaded on reset
- i_clk  in  1  clock, all state updates on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_start  in  1  debug unit: leave IDLE and begin execution
- i_step_mode  in  1  sampled in IDLE with i_start: 0 = continuous, 1 = single-step
- i_step  in  1  one-cycle pulse: advance one cycle in STEP mode
- i_stall  in  1  hazard unit: hold PC this cycle
- i_branch_taken  in  1  ID stage: branch resolved taken
- i_branch_offset  in  BITS_SIZE  sign-extended branch immediate (word offset)
- i_branch_pc4  in  BITS_SIZE  PC+4 of the branch instruction
- i_jump  in  1  ID stage: unconditional jump / jump register
- i_jump_addr  in  BITS_SIZE  jump target
- i_halt  in  1  HALT opcode fetched
- o_pc  out  BITS_SIZE  current fetch address
- o_pc4  out  BITS_SIZE  o_pc + 4, combinational
- o_flush  out  1  squash instruction in IF/ID
- o_pc_valid  out  1  o_pc is a fetch this cycle (pipeline enable)
- o_halted  out  1  sequencer in HALTED state

## Operation
- States: IDLE, RUN, STEP, HALTED.
- IDLE: PC held, o_pc_valid=0. On i_start, go to RUN if i_step_mode=0, otherwise to STEP.
- RUN: an advance is permitted every cycle.
- STEP: an advance is permitted only in cycles with i_step=1. o_pc_valid equals i_step.
- HALTED: terminal until reset. PC frozen, o_pc_valid=0, o_flush=0, o_halted=1. All other inputs are ignored.
- Next-PC selection in a permitted-advance cycle, highest priority first:
  1. i_halt=1: PC held; go to HALTED at the next edge.
  2. i_stall=1: PC held, no flush. A redirect asserted in the same cycle is not consumed; ID holds it until the stall drops.
  3. i_jump=1: PC ← i_jump_addr with bits [1:0] forced to 0; o_flush=1 next cycle.
  4. i_branch_taken=1: PC ← (i_branch_offset<<2) + i_branch_pc4; o_flush=1 next cycle. If i_jump and i_branch_taken are both asserted, the jump wins.
  5. Otherwise: PC ← PC+4.
- Arithmetic is modulo 2^BITS_SIZE. Bits shifted out of the offset are discarded. 0xFFFFFFFC+4 wraps to 0x00000000 without error.
- Cycles without a permitted advance (STEP without i_step, IDLE) hold the PC and ignore i_stall, i_jump, i_branch_taken and i_halt.

## Timing
- Reset (async assert, sync release) sets: state=IDLE, o_pc=RESET_PC, o_pc4=RESET_PC+4, o_flush=0, o_pc_valid=0, o_halted=0.
- Reset asserted mid-operation, in any state, takes effect immediately and discards any pending redirect or flush.
- PC update latency: 1 cycle. A redirect sampled at edge N appears on o_pc after edge N.
- o_flush is registered: high for exactly the one cycle following the redirect edge, aligned with the first fetch at the target. Back-to-back redirects give back-to-back flush cycles.
- o_pc_valid:
  - RUN: registered-free combinational decode of state, equal to 1.
  - STEP: equal to i_step.
  - IDLE and HALTED: 0.
- Leaving IDLE: o_pc_valid first goes high in the cycle after the i_start edge, with o_pc=RESET_PC.
- o_halted rises the cycle after the edge that sampled i_halt.

## Test plan
- Reset, i_start with i_step_mode=0, no events → o_pc = 0, 4, 8, 12 on successive cycles, o_flush=0 throughout.
- In RUN at o_pc=0x20: i_branch_taken=1, offset=0xFFFFFFFE, pc4=0x20 → next o_pc=0x18, o_flush=1 for one cycle, then 0x1C.
- Simultaneous i_stall=1 and i_jump=1 (addr 0x103) for 2 cycles, then the stall drops with the jump held → PC held 2 cycles, then o_pc=0x100 and a single flush.
- i_jump and i_branch_taken together → jump target taken. Also start at 0xFFFFFFF8 → sequence 0xFFFFFFFC, 0x00000000.
- Step mode: i_start with i_step_mode=1, pulse i_step at cycles 3 and 7 → o_pc advances 0→4→8 only after those edges, o_pc_valid high only in cycles 3 and 7.
- i_halt at o_pc=0x40, then reset asserted mid-HALTED → o_halted=1 and o_pc frozen at 0x40; after reset, o_pc=RESET_PC, state IDLE, all outputs at reset values.
